// File: rtl/gpio_in_filter.sv
// ---------------------------------------------------------------------------
// gpio_in_filter
//
// Debounces a bank of asynchronous GPIO input pins and captures selected
// edges of the debounced levels as sticky, individually clearable flags.
//
// Each pin goes through a two-flop synchronizer (r_s1 -> r_s2). A per-pin
// counter then measures how long r_s2 has disagreed with the debounced
// level. Once that disagreement has lasted beyond the pin's selected
// threshold, the debounced level follows the pin.
//
// After reset a small sequencer runs INIT (2 cycles) -> LOAD (1 cycle) -> RUN.
// LOAD copies the synchronized pins straight into filt_data, so pins that are
// already high when the block comes out of reset do not report an edge.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   pin_in       : raw pin levels, asynchronous to clk
//   filt_sel     : per-pin threshold select (1 = slow_thresh, 0 = fast_thresh)
//   slow_thresh  : slow debounce threshold
//   fast_thresh  : fast debounce threshold
//   rise_en      : per-pin capture enable for debounced 0->1 transitions
//   fall_en      : per-pin capture enable for debounced 1->0 transitions
//   clr_strobe   : clear request qualifier for clr_mask
//   clr_mask     : edge_status bits to clear when clr_strobe is high
//   filt_data    : debounced pin levels
//   edge_status  : sticky edge-captured flags
//   irq          : OR of all edge_status bits
//   ready        : high only while the sequencer is in RUN
//   dbg_state    : current sequencer state (INIT=0, LOAD=1, RUN=2)
// ---------------------------------------------------------------------------
module gpio_in_filter #(
   parameter int IOWidth   = 36,
   parameter int FiltWidth = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IOWidth-1:0]   pin_in,
   input  logic [IOWidth-1:0]   filt_sel,
   input  logic [FiltWidth-1:0] slow_thresh,
   input  logic [FiltWidth-1:0] fast_thresh,
   input  logic [IOWidth-1:0]   rise_en,
   input  logic [IOWidth-1:0]   fall_en,
   input  logic                 clr_strobe,
   input  logic [IOWidth-1:0]   clr_mask,
   output logic [IOWidth-1:0]   filt_data,
   output logic [IOWidth-1:0]   edge_status,
   output logic                 irq,
   output logic                 ready,
   output logic [1:0]           dbg_state
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [FiltWidth-1:0] CntOne = FiltWidth'(1);

   logic [1:0]         r_state;
   logic               r_init_cnt;
   logic [IOWidth-1:0] r_s1;
   logic [IOWidth-1:0] r_s2;
   logic [IOWidth-1:0] r_filt;
   logic [IOWidth-1:0] r_status;

   logic               w_run;
   logic               w_load;
   logic [IOWidth-1:0] w_take;
   logic [IOWidth-1:0] w_filt_nxt;
   logic [IOWidth-1:0] w_set;
   logic [IOWidth-1:0] w_clr;

   assign w_run  = (r_state == ST_RUN);
   assign w_load = (r_state == ST_LOAD);

   // ------------------------------------------------------------------
   // Sequencer: INIT for two cycles after reset releases, LOAD for one,
   // then RUN until the next reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_INIT;
         r_init_cnt <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_cnt) begin
                  r_state <= ST_LOAD;
               end
               r_init_cnt <= 1'b1;
            end
            ST_LOAD: r_state <= ST_RUN;
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // Two-flop synchronizer in front of everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= pin_in;
         r_s2 <= r_s1;
      end
   end

   // ------------------------------------------------------------------
   // Per-pin debounce counters. The counter holds the number of cycles
   // r_s2 has already disagreed with filt_data; '>=' lets a threshold
   // lowered mid-count take effect on the very next edge.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < IOWidth; g++) begin : g_pin
      logic [FiltWidth-1:0] r_cnt;
      logic [FiltWidth-1:0] w_thr;
      logic                 w_diff;

      assign w_thr     = filt_sel[g] ? slow_thresh : fast_thresh;
      assign w_diff    = r_s2[g] ^ r_filt[g];
      assign w_take[g] = w_run & w_diff & (r_cnt >= w_thr);

      always_ff @(posedge clk) begin
         if (reset || w_load) begin
            r_cnt <= '0;
         end else if (w_run) begin
            if (!w_diff || w_take[g]) begin
               r_cnt <= '0;
            end else if (r_cnt != '1) begin
               // Saturate rather than wrap.
               r_cnt <= r_cnt + CntOne;
            end
         end
      end
   end

   assign w_filt_nxt = r_filt ^ w_take;
   assign w_set      = w_take & ((w_filt_nxt & rise_en) | (~w_filt_nxt & fall_en));
   assign w_clr      = clr_mask & {IOWidth{clr_strobe}};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt <= '0;
      end else if (w_load) begin
         r_filt <= r_s2;
      end else if (w_run) begin
         r_filt <= w_filt_nxt;
      end
   end

   // A set on the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_status <= '0;
      end else begin
         r_status <= w_set | (r_status & ~w_clr);
      end
   end

   assign filt_data   = r_filt;
   assign edge_status = r_status;
   assign irq         = |r_status;
   assign ready       = w_run;
   assign dbg_state   = r_state;

endmodule
